// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension stage: the extension-mode
// encodings used by decode control and by the extension datapath.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SEXT   = 2'd0;  // sign-extend
  localparam logic [1:0] MODE_ZEXT   = 2'd1;  // zero-extend
  localparam logic [1:0] MODE_UPPER  = 2'd2;  // place in top bits, zero below
  localparam logic [1:0] MODE_BRANCH = 2'd3;  // sign-extend, then shift left

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Purely combinational immediate extender: widens an IN_W-bit immediate to
// OUT_W bits in one of the four extension modes.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHIFT_B = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] data
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;
  logic [OUT_W-1:0] upper_val;
  logic [OUT_W-1:0] branch_val;

  assign sext_val   = {{PAD_W{imm[IN_W-1]}}, imm};
  assign zext_val   = {{PAD_W{1'b0}}, imm};
  assign upper_val  = {imm, {PAD_W{1'b0}}};
  // Bits shifted past OUT_W are dropped; the vacated low bits fill with zero.
  assign branch_val = sext_val << SHIFT_B;

  // Mode mux selecting the extended result.
  always_comb begin
    // NOTE: data gets a value on every path (default arm included), so no
    // latch is inferred for this combinational output.
    case (mode)
      MODE_SEXT:   data = sext_val;
      MODE_ZEXT:   data = zext_val;
      MODE_UPPER:  data = upper_val;
      MODE_BRANCH: data = branch_val;
      default:     data = sext_val;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension stage: extends the accepted immediate and
// holds it in a main output register backed by one skid register, so
// downstream backpressure never drops or duplicates an immediate while
// in_ready stays a registered-derived signal.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHIFT_B = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  if ((IN_W < 1) || (IN_W >= OUT_W)) begin : g_bad_params
    $error("imm_extend_pipe: IN_W (%0d) must satisfy 1 <= IN_W < OUT_W (%0d)",
           IN_W, OUT_W);
  end

  logic [OUT_W-1:0] ext_data;

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;

  logic in_fire;
  logic out_fire;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .SHIFT_B (SHIFT_B)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .data (ext_data)
  );

  // Accept whenever the skid slot is free; never looks at out_ready.
  assign in_ready  = !skid_valid_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid_q && out_ready;

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  // Next-state for the two-entry buffer: drain first, then place new input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (out_fire) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    // in_fire implies the skid slot is empty, so a draining main register
    // can take the new item directly and FIFO order is preserved.
    if (in_fire) begin
      if (!main_valid_q || out_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ext_data;
      end
    end
  end

  // Buffer state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are cleared too, not just the valid bits, so
      // out_data reads 0 in reset and no stale value survives a reset.
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: a queue-based FIFO model with an
// arithmetic extension model, checked every cycle, plus directed literal
// expectations for both the default and an 8->16 parametrisation.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  logic        a_in_valid;
  logic        a_in_ready;
  logic [7:0]  a_in_imm;
  logic [1:0]  a_in_mode;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [15:0] a_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned exp_q[$];
  longint unsigned seen[$];

  imm_extend_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .SHIFT_B(1)) dut_alt (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_imm    (a_in_imm),
    .in_mode   (a_in_mode),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Extension rules as plain integer arithmetic modulo 2**out_w.
  function automatic longint unsigned ext_model(longint unsigned imm, int mode,
                                                int in_w, int out_w, int sh);
    longint unsigned mo = 64'd1 << out_w;
    longint unsigned s  = imm;
    if (imm >= (64'd1 << (in_w - 1))) s = imm + mo - (64'd1 << in_w);
    case (mode)
      0:       return s;
      1:       return imm;
      2:       return (imm * (64'd1 << (out_w - in_w))) % mo;
      default: return (s * (64'd1 << sh)) % mo;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle scoreboard, sampled mid-cycle while everything is stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("sb_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      check("sb_in_ready",  {63'd0, in_ready},  {63'd0, exp_q.size() < 2});
      if (exp_q.size() > 0) check("sb_out_data", {32'd0, out_data}, exp_q[0]);
      if (out_valid && out_ready && exp_q.size() > 0) seen.push_back(exp_q.pop_front());
      if (in_valid && in_ready)
        exp_q.push_back(ext_model(in_imm, int'(in_mode), 16, 32, 2));
    end
  end

  // Present one item and hold it until accepted; returns at edge+1.
  task automatic push(input logic [15:0] imm, input logic [1:0] mode);
    int  n   = 0;
    logic acc = 1'b0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check("push_accept", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  // Single item with out_ready=1: result must show one cycle after acceptance.
  task automatic send_one(input string name, input logic [15:0] imm,
                          input logic [1:0] mode, input logic [31:0] exp);
    check({name, "_model"}, ext_model(imm, int'(mode), 16, 32, 2), {32'd0, exp});
    push(imm, mode);
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_data"},  {32'd0, out_data},  {32'd0, exp});
  endtask

  task automatic alt_one(input string name, input logic [7:0] imm,
                         input logic [1:0] mode, input logic [15:0] exp);
    check({name, "_model"}, ext_model(imm, int'(mode), 8, 16, 1), {48'd0, exp});
    a_in_valid = 1'b1;
    a_in_imm   = imm;
    a_in_mode  = mode;
    @(negedge clk);
    check({name, "_ready"}, {63'd0, a_in_ready}, 64'd1);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    check({name, "_valid"}, {63'd0, a_out_valid}, 64'd1);
    check({name, "_data"},  {48'd0, a_out_data},  {48'd0, exp});
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_mode     = '0;
    out_ready   = 1'b1;
    a_in_valid  = 1'b0;
    a_in_imm    = '0;
    a_in_mode   = '0;
    a_out_ready = 1'b1;

    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  {32'd0, out_data},  64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed extension cases, default widths.
    send_one("sext_000f", 16'h000F, 2'd0, 32'h0000000F);
    send_one("sext_007f", 16'h007F, 2'd0, 32'h0000007F);
    send_one("sext_8000", 16'h8000, 2'd0, 32'hFFFF8000);
    send_one("sext_ffff", 16'hFFFF, 2'd0, 32'hFFFFFFFF);
    send_one("zext_ffff", 16'hFFFF, 2'd1, 32'h0000FFFF);
    send_one("upper_1234", 16'h1234, 2'd2, 32'h12340000);
    send_one("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFFFFFC);
    send_one("branch_007f", 16'h007F, 2'd3, 32'h000001FC);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: items 1 and 2 fill both registers, item 3 must wait.
    seen.delete();
    out_ready = 1'b0;
    push(16'd1, 2'd0);
    push(16'd2, 2'd0);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_hold_data",    {32'd0, out_data}, 64'd1);
    fork
      push(16'd3, 2'd0);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
          check("bp_stall_ready", {63'd0, in_ready},  64'd0);
          check("bp_stall_data",  {32'd0, out_data},  64'd1);
          check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", seen.size(), 64'd3);
    if (seen.size() == 3) begin
      check("bp_order0", seen[0], 64'd1);
      check("bp_order1", seen[1], 64'd2);
      check("bp_order2", seen[2], 64'd3);
    end

    // Streaming: 8 back-to-back inputs with out_ready held high.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'($urandom);
      in_mode  = 2'($urandom);
      @(negedge clk);
      check("stream_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check("stream_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_drained", {63'd0, out_valid}, 64'd0);

    // Randomised traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation with both registers full.
    out_ready = 1'b0;
    push(16'h00AA, 2'd1);
    push(16'h00BB, 2'd1);
    check("mid_full", {63'd0, in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_data",  {32'd0, out_data},  64'd0);
    check("mid_rst_ready", {63'd0, in_ready},  64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_valid", {63'd0, out_valid}, 64'd0);
    end

    // Alternate parametrisation: IN_W=8, OUT_W=16, SHIFT_B=1.
    alt_one("alt_sext_80",   8'h80, 2'd0, 16'hFF80);
    alt_one("alt_zext_80",   8'h80, 2'd1, 16'h0080);
    alt_one("alt_upper_ab",  8'hAB, 2'd2, 16'hAB00);
    alt_one("alt_branch_c0", 8'hC0, 2'd3, 16'hFF80);
    @(posedge clk);
    #1;
    check("alt_drained", {63'd0, a_out_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imm_extend_pipe
